lsu_v3: RTL and testbench



---
 rtl/lsu_v3.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_v3.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/lsu_v3.sv
// Pipelined load/store unit: byte-banked data RAM, memory-mapped LED/HEX/LCD
// registers and synchronised switch/button inputs with clear-on-read press latches.
module lsu_v3 #(
  parameter int DMEM_AW  = 14,
  parameter int RD_LAT   = 1,
  parameter int NUM_SW   = 9,
  parameter int NUM_BTN  = 4,
  parameter int NUM_LEDR = 10,
  parameter int NUM_HEX  = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_i,
  input  logic                   wren_i,
  input  logic [2:0]             funct3_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            st_data_i,
  input  logic [NUM_SW-1:0]      io_sw_i,
  input  logic [NUM_BTN-1:0]     io_btn_i,
  output logic                   ready_o,
  output logic                   rvalid_o,
  output logic [31:0]            ld_data_o,
  output logic                   err_o,
  output logic [NUM_LEDR-1:0]    io_ledr_o,
  output logic [7*NUM_HEX-1:0]   io_hex_o,
  output logic [31:0]            io_lcd_o
);
  localparam int DEPTH = 1 << DMEM_AW;

  logic               ready_reg, acc, err_req, store_ok, ram_we, out_we, clr;
  logic [1:0]         region, size, off;
  logic [3:0]         be;
  logic [31:0]        wdata, out_word, in_word, ram_word, ledr_word;
  logic [DMEM_AW-1:0] ram_idx;

  assign region   = addr_i[17:16];
  assign size     = funct3_i[1:0];
  assign off      = addr_i[1:0];
  assign ram_idx  = addr_i[DMEM_AW+1:2];
  assign acc      = req_i && ready_reg;
  // Misalignment, illegal size and stores into the read-only input region all error
  assign err_req  = (size == 2'b11) || (size == 2'b01 && off[0]) ||
                    (size == 2'b10 && off != 2'b00) || (wren_i && region == 2'b11);
  assign store_ok = acc && wren_i && !err_req;
  assign ram_we   = store_ok && region == 2'b01;
  assign out_we   = store_ok && region == 2'b10;
  assign wdata    = st_data_i << {off, 3'b000};
  // Aligned accesses touch byte 0x8 exactly when lane 0 of word 2 is enabled
  assign clr      = acc && !wren_i && !err_req && region == 2'b11 &&
                    addr_i[3:2] == 2'd2 && be[0];

  always_comb begin
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ready_reg <= 1'b0;
    else       ready_reg <= 1'b1;
  end
  assign ready_o = ready_reg;

  logic [NUM_SW-1:0]  sw_s1_reg, sw_s2_reg;
  logic [NUM_BTN-1:0] btn_s1_reg, btn_s2_reg, btn_prev_reg, press_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sw_s1_reg    <= '0;
      sw_s2_reg    <= '0;
      btn_s1_reg   <= '0;
      btn_s2_reg   <= '0;
      btn_prev_reg <= '0;
      press_reg    <= '0;
    end else begin
      sw_s1_reg    <= io_sw_i;
      sw_s2_reg    <= sw_s1_reg;
      btn_s1_reg   <= io_btn_i;
      btn_s2_reg   <= btn_s1_reg;
      btn_prev_reg <= btn_s2_reg;
      press_reg    <= (press_reg & ~{NUM_BTN{clr}}) | (btn_s2_reg & ~btn_prev_reg);
    end
  end

  // Output region as 16 byte registers; HEX bytes past NUM_HEX are never written
  logic [7:0] out_bytes [16];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int b = 0; b < 16; b++) out_bytes[b] <= '0;
    end else if (out_we) begin
      for (int b = 0; b < 16; b++)
        if ((b < 4 + NUM_HEX || b >= 12) && addr_i[3:2] == 2'(b / 4) && be[b % 4])
          out_bytes[b] <= wdata[8*(b % 4) +: 8];
    end
  end

  assign out_word  = {out_bytes[{addr_i[3:2], 2'd3}], out_bytes[{addr_i[3:2], 2'd2}],
                      out_bytes[{addr_i[3:2], 2'd1}], out_bytes[{addr_i[3:2], 2'd0}]};
  assign ledr_word = {out_bytes[3], out_bytes[2], out_bytes[1], out_bytes[0]};
  assign io_ledr_o = ledr_word[NUM_LEDR-1:0];
  assign io_lcd_o  = {out_bytes[15], out_bytes[14], out_bytes[13], out_bytes[12]};

  for (genvar gi = 0; gi < NUM_HEX; gi++) begin : g_hex
    assign io_hex_o[7*gi +: 7] = out_bytes[4+gi][6:0];
  end

  always_comb begin
    case (addr_i[3:2])
      2'd0:    in_word = {16'h0, 16'(sw_s2_reg)};
      2'd1:    in_word = {24'h0, 8'(btn_s2_reg)};
      2'd2:    in_word = {24'h0, 8'(press_reg)};
      default: in_word = '0;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    logic [7:0] mem [DEPTH];
    logic [7:0] q_reg;
    always_ff @(posedge clk_i) begin
      if (ram_we && be[gi]) mem[ram_idx] <= wdata[8*gi +: 8];
      q_reg <= mem[ram_idx];
    end
    assign ram_word[8*gi +: 8] = q_reg;
  end

  // Stage 1 runs in parallel with the RAM's registered read
  logic        s1_valid_reg, s1_err_reg, s1_ram_reg;
  logic [2:0]  s1_f3_reg;
  logic [1:0]  s1_off_reg;
  logic [31:0] s1_io_reg, word, shifted, fmt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_ram_reg   <= 1'b0;
      s1_f3_reg    <= '0;
      s1_off_reg   <= '0;
      s1_io_reg    <= '0;
    end else begin
      s1_valid_reg <= acc && !wren_i;
      s1_err_reg   <= acc && err_req;
      s1_ram_reg   <= region == 2'b01;
      s1_f3_reg    <= funct3_i;
      s1_off_reg   <= off;
      s1_io_reg    <= (region == 2'b10) ? out_word : (region == 2'b11) ? in_word : '0;
    end
  end

  always_comb begin
    word    = s1_ram_reg ? ram_word : s1_io_reg;
    shifted = word >> {s1_off_reg, 3'b000};
    case (s1_f3_reg)
      3'b000:  fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  fmt = {24'h0, shifted[7:0]};
      3'b101:  fmt = {16'h0, shifted[15:0]};
      default: fmt = shifted;
    endcase
    if (s1_err_reg || !s1_valid_reg) fmt = '0;
  end

  logic        s2_valid_reg, s2_err_reg;
  logic [31:0] s2_data_reg;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s2_valid_reg <= 1'b0;
      s2_err_reg   <= 1'b0;
      s2_data_reg  <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_err_reg   <= s1_err_reg;
      s2_data_reg  <= fmt;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic        s3_valid_reg, s3_err_reg;
    logic [31:0] s3_data_reg;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        s3_valid_reg <= 1'b0;
        s3_err_reg   <= 1'b0;
        s3_data_reg  <= '0;
      end else begin
        s3_valid_reg <= s2_valid_reg;
        s3_err_reg   <= s2_err_reg;
        s3_data_reg  <= s2_data_reg;
      end
    end
    assign rvalid_o  = s3_valid_reg;
    assign err_o     = s3_err_reg;
    assign ld_data_o = s3_data_reg;
  end else begin : g_lat1
    assign rvalid_o  = s2_valid_reg;
    assign err_o     = s2_err_reg;
    assign ld_data_o = s2_data_reg;
  end

  logic unused_ok;
  assign unused_ok = ^{addr_i, ledr_word};
endmodule

// File: tb/tb_lsu_v3.sv
// Directed bench for lsu_v3 with RD_LAT=2: vector table plus hand-written
// reset, read-after-write, back-to-back and press-latch sequences.
module tb_lsu_v3;
  localparam int LAT = 2;

  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, wren = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0, sdata = '0;
  logic [8:0]  sw = 9'h1A5;
  logic [3:0]  btn = '0;
  logic        ready, rvalid, err;
  logic [31:0] ldata, lcd;
  logic [9:0]  ledr;
  logic [41:0] hex;

  lsu_v3 #(.DMEM_AW(10), .RD_LAT(LAT), .NUM_SW(9), .NUM_BTN(4), .NUM_LEDR(10), .NUM_HEX(6)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .wren_i(wren), .funct3_i(f3), .addr_i(addr),
    .st_data_i(sdata), .io_sw_i(sw), .io_btn_i(btn), .ready_o(ready), .rvalid_o(rvalid),
    .ld_data_o(ldata), .err_o(err), .io_ledr_o(ledr), .io_hex_o(hex), .io_lcd_o(lcd)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, total = 0;

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        eerr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic add(input string n, input logic w, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] e, input logic ee);
    vec_t v;
    v.name = n; v.wr = w; v.f3 = f; v.addr = a; v.data = d; v.exp = e; v.eerr = ee;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; wren = w; f3 = f; addr = a; sdata = d;
  endtask

  // Leaves the bench at the negedge where the response (or store error pulse) is visible
  task automatic access(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    drive(w, f, a, d);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (LAT) @(negedge clk);
  endtask

  initial begin
    int got;
    add("sw_ram",      1, 3'b010, 32'h0001_0004, 32'h8765_4321, 32'h0,         0);
    add("lb_ram",      0, 3'b000, 32'h0001_0007, 32'h0,         32'hFFFF_FF87, 0);
    add("lbu_ram",     0, 3'b100, 32'h0001_0007, 32'h0,         32'h0000_0087, 0);
    add("lhu_ram",     0, 3'b101, 32'h0001_0004, 32'h0,         32'h0000_4321, 0);
    add("lh_ram",      0, 3'b001, 32'h0001_0006, 32'h0,         32'hFFFF_8765, 0);
    add("lw_ram",      0, 3'b010, 32'h0001_0004, 32'h0,         32'h8765_4321, 0);
    add("f3_110_lw",   0, 3'b110, 32'h0001_0004, 32'h0,         32'h8765_4321, 0);
    add("lw_misalign", 0, 3'b010, 32'h0001_0002, 32'h0,         32'h0,         1);
    add("ld_illegal",  0, 3'b011, 32'h0001_0004, 32'h0,         32'h0,         1);
    add("sh_misalign", 1, 3'b001, 32'h0002_0005, 32'h0000_1234, 32'h0,         1);
    add("lbu_hex1",    0, 3'b100, 32'h0002_0005, 32'h0,         32'h0,         0);
    add("sb_hex5",     1, 3'b000, 32'h0002_0009, 32'h0000_003F, 32'h0,         0);
    add("sw_ledr",     1, 3'b010, 32'h0002_0000, 32'h0000_03FF, 32'h0,         0);
    add("lb_hex7",     0, 3'b000, 32'h0002_000B, 32'h0,         32'h0,         0);
    add("lw_hex_w2",   0, 3'b010, 32'h0002_0008, 32'h0,         32'h0000_3F00, 0);
    add("lw_ledr",     0, 3'b010, 32'h0002_0000, 32'h0,         32'h0000_03FF, 0);
    add("sb_lcd",      1, 3'b000, 32'h0002_000C, 32'h0000_00A5, 32'h0,         0);
    add("lw_lcd",      0, 3'b010, 32'h0002_000C, 32'h0,         32'h0000_00A5, 0);
    add("lhu_sw",      0, 3'b101, 32'h0003_0000, 32'h0,         32'h0000_01A5, 0);
    add("sw_input",    1, 3'b010, 32'h0003_0000, 32'h1111_1111, 32'h0,         1);
    add("sw_unmapped", 1, 3'b010, 32'h0000_0000, 32'h1111_1111, 32'h0,         0);
    add("lw_unmapped", 0, 3'b010, 32'h0000_0010, 32'h0,         32'h0,         0);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_err", err, 0);
    chk("rst_ldata", ldata, 0);
    chk("rst_io", {ledr, hex, lcd}, 0);
    rst = 1'b0;
    chk("ready_before_edge", ready, 0);
    @(negedge clk);
    chk("ready_after_edge", ready, 1);

    foreach (vecs[i]) begin
      access(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].data);
      chk({vecs[i].name, "_rvalid"}, rvalid, !vecs[i].wr);
      chk({vecs[i].name, "_err"}, err, vecs[i].eerr);
      if (!vecs[i].wr) chk({vecs[i].name, "_data"}, ldata, vecs[i].exp);
      $display("vec %0d %s addr=0x%08h rvalid=%0b err=%0b data=0x%08h", i, vecs[i].name,
               vecs[i].addr, rvalid, err, ldata);
    end
    chk("io_ledr", ledr, 10'h3FF);
    chk("io_hex5", hex[41:35], 7'h3F);
    chk("io_hex1", hex[13:7], 7'h00);
    chk("io_lcd", lcd, 32'h0000_00A5);

    // Read-after-write on consecutive cycles
    drive(1, 3'b010, 32'h0001_0020, 32'hCAFE_BABE);
    @(posedge clk); @(negedge clk);
    drive(1, 3'b000, 32'h0001_0021, 32'h0000_005A);
    @(posedge clk); @(negedge clk);
    access(0, 3'b010, 32'h0001_0020, 32'h0);
    chk("raw_rvalid", rvalid, 1);
    chk("raw_data", ldata, 32'hCAFE_5ABE);
    $display("raw data=0x%08h", ldata);

    // Back-to-back loads
    for (int k = 0; k < 4; k++) access(1, 3'b010, 32'h0001_0040 + 4 * k, 32'h1000_0000 + k);
    got = 0;
    drive(0, 3'b010, 32'h0001_0040, 32'h0);
    for (int cyc = 0; cyc < 4 + LAT + 2; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (cyc + 1 < 4) addr = 32'h0001_0040 + 4 * (cyc + 1);
      else req = 1'b0;
      if (rvalid) begin
        chk($sformatf("b2b_data%0d", got), ldata, 32'h1000_0000 + got);
        chk($sformatf("b2b_cycle%0d", got), cyc, got + LAT);
        $display("b2b resp %0d cyc=%0d data=0x%08h", got, cyc, ldata);
        got++;
      end
    end
    chk("b2b_count", got, 4);

    // Single-cycle button pulse, read twice
    btn = 4'b0100;
    @(negedge clk);
    btn = 4'b0000;
    repeat (4) @(negedge clk);
    access(0, 3'b100, 32'h0003_0008, 32'h0);
    chk("latch_first", ldata, 32'h04);
    $display("latch read1 data=0x%08h", ldata);
    access(0, 3'b100, 32'h0003_0008, 32'h0);
    chk("latch_cleared", ldata, 32'h00);
    $display("latch read2 data=0x%08h", ldata);

    // Edge lands on the clearing read's acceptance edge: set wins
    btn = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    access(0, 3'b100, 32'h0003_0008, 32'h0);
    chk("latch_race_old", ldata, 32'h00);
    btn = 4'b0000;
    access(0, 3'b100, 32'h0003_0008, 32'h0);
    chk("latch_race_kept", ldata, 32'h04);
    $display("latch race data=0x%08h", ldata);

    // Reset with a load in flight
    drive(0, 3'b010, 32'h0001_0004, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("midrst_rvalid%0d", c), rvalid, 0);
      @(negedge clk);
    end
    chk("midrst_io", {ledr, hex, lcd}, 0);
    chk("midrst_ready", ready, 0);
    rst = 1'b0;
    chk("midrst_rvalid_rel", rvalid, 0);
    @(negedge clk);
    chk("midrst_ready_rel", ready, 1);
    chk("midrst_rvalid_after", rvalid, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
